// File: rtl/ct_f_spsram_req_ctrl.sv
// Request front-end for the 8192x128 single-port SRAM: valid/ready requests to CEN/GWEN/WEN strobes,
// read data into a small response FIFO. Macro CT_F_SPSRAM_INIT_EN enables the post-reset zero sweep.
module ct_f_spsram_req_ctrl #(
  parameter int                    ADDR_WIDTH = 13,
  parameter int                    DATA_WIDTH = 128,
  parameter int                    RSP_DEPTH  = 2,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  req_vld,
  output logic                  req_rdy,
  input  logic                  req_wr,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_vld,
  input  logic                  rsp_rdy,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  init_done,
  output logic [ADDR_WIDTH-1:0] sram_a,
  output logic                  sram_cen,
  output logic                  sram_gwen,
  output logic [DATA_WIDTH-1:0] sram_wen,
  output logic [DATA_WIDTH-1:0] sram_d,
  input  logic [DATA_WIDTH-1:0] sram_q
);

  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;
`ifdef CT_F_SPSRAM_INIT_EN
  localparam state_t RST_STATE = ST_INIT;
`else
  localparam state_t RST_STATE = ST_RUN;
`endif

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_init_addr;
  logic                  r_rd_inflight;
  logic [DATA_WIDTH-1:0] r_fifo [RSP_DEPTH];
  logic [PW-1:0]         r_wptr, r_rptr;
  logic [CW-1:0]         r_cnt;
  logic                  w_push, w_pop, w_room, w_acc, w_run;
  logic [CW:0]           w_occ;

  function automatic logic [PW-1:0] f_inc(input logic [PW-1:0] p);
    return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign rsp_vld   = (r_cnt != '0);
  assign rsp_rdata = r_fifo[r_rptr];
  assign w_pop     = rsp_vld && rsp_rdy;
  assign w_push    = r_rd_inflight;

  // Occupancy counts the read whose Q lands this cycle, less the entry leaving now.
  assign w_occ  = {1'b0, r_cnt} + (CW+1)'(r_rd_inflight) - (CW+1)'(w_pop);
  assign w_room = (w_occ < (CW+1)'(RSP_DEPTH));

  // Gating with cpurst_b keeps outputs idle while reset is held, even when the FSM resets into RUN.
  assign w_run     = cpurst_b && (r_state == ST_RUN);
  assign init_done = w_run;
  assign req_rdy   = w_run && w_room;
  assign w_acc     = req_vld && req_rdy;

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) r_state <= RST_STATE;
    else           r_state <= w_state_nxt;
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b)                r_init_addr <= '0;
    else if (r_state == ST_INIT)  r_init_addr <= r_init_addr + 1'b1;
  end

  always_comb begin
    w_state_nxt = r_state;
    sram_a      = '0;
    sram_cen    = 1'b1;
    sram_gwen   = 1'b1;
    sram_wen    = {DATA_WIDTH{1'b1}};
    sram_d      = '0;
    case (r_state)
      ST_INIT: begin
        if (cpurst_b) begin
          sram_a    = r_init_addr;
          sram_cen  = 1'b0;
          sram_gwen = 1'b0;
          sram_wen  = '0;
          sram_d    = INIT_VALUE;
        end
        if (r_init_addr == {ADDR_WIDTH{1'b1}}) w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (w_acc) begin
          sram_a    = req_addr;
          sram_cen  = 1'b0;
          sram_gwen = ~req_wr;
          sram_wen  = {DATA_WIDTH{~req_wr}};
          sram_d    = req_wdata;
        end
      end
      default: w_state_nxt = RST_STATE;
    endcase
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      r_rd_inflight <= 1'b0;
      r_cnt         <= '0;
      r_wptr        <= '0;
      r_rptr        <= '0;
    end else begin
      r_rd_inflight <= w_acc && !req_wr;
      r_cnt         <= r_cnt + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wptr <= f_inc(r_wptr);
      if (w_pop)  r_rptr <= f_inc(r_rptr);
    end
  end

  always_ff @(posedge forever_cpuclk) begin
    if (w_push) r_fifo[r_wptr] <= sram_q;
  end

  a_no_overflow: assert property (@(posedge forever_cpuclk) disable iff (!cpurst_b)
    !(w_push && !w_pop && (r_cnt == CW'(RSP_DEPTH))));

endmodule

// File: tb/tb_ct_f_spsram_req_ctrl.sv
// Bench for ct_f_spsram_req_ctrl: SRAM model, table vectors, corner sequences, random traffic vs a queue model.
module tb_ct_f_spsram_req_ctrl;
  localparam int AW = 13;
  localparam int DW = 128;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_vld = 1'b0, req_wr = 1'b0, rsp_rdy = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_rdy, rsp_vld, init_done, sram_cen, sram_gwen;
  logic [DW-1:0] rsp_rdata, sram_wen, sram_d;
  logic [DW-1:0] sram_q = '0;
  logic [AW-1:0] sram_a;

  always #5 clk = ~clk;

  ct_f_spsram_req_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(DEPTH)) dut (
    .forever_cpuclk(clk), .cpurst_b(rst_n),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_rdata(rsp_rdata), .init_done(init_done),
    .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen), .sram_wen(sram_wen),
    .sram_d(sram_d), .sram_q(sram_q));

  logic [DW-1:0] smem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (!sram_cen) begin
      if (!sram_gwen) smem[sram_a] <= (smem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
      else            sram_q <= smem[sram_a];
    end
  end

  // Reference model: outstanding reads in order, with the cycle each was accepted.
  typedef struct { logic [DW-1:0] data; bit known; int cyc; } rd_t;
  rd_t           q[$];
  logic [DW-1:0] mm[int];
  bit            m_run = 0, chk_model = 0;
  int            cyc = 0, n_tests = 0, n_fail = 0;

  typedef struct {
    bit vld; bit wr; logic [AW-1:0] addr; bit rrdy;
    bit e_rdy; bit e_cen; bit e_gwen; bit e_vld; bit e_chkd; logic [DW-1:0] e_data;
  } vec_t;
  vec_t tv[14];

  function automatic logic [DW-1:0] pat(input int a);
    return {4{32'hC0DE0000 + a}};
  endfunction

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic eval();
    bit ev, pop, erdy, acc, wacc;
    rd_t r;
    @(negedge clk);
    ev   = (q.size() > 0) && ((cyc - q[0].cyc) >= 2);
    pop  = ev && rsp_rdy;
    erdy = m_run && ((q.size() - int'(pop)) < DEPTH);
    acc  = req_vld && erdy;
    wacc = acc && req_wr;
    if (chk_model) begin
      chk("m_init_done", init_done, m_run);
      chk("m_req_rdy", req_rdy, erdy);
      chk("m_rsp_vld", rsp_vld, ev);
      chk("m_cen", sram_cen, !acc);
      chk("m_gwen", sram_gwen, !wacc);
      chk("m_wen", sram_wen, wacc ? '0 : {DW{1'b1}});
      chk("m_a", sram_a, acc ? req_addr : '0);
      chk("m_d", sram_d, acc ? req_wdata : '0);
      if (pop && q[0].known) chk("m_rdata", rsp_rdata, q[0].data);
    end
    if (pop) void'(q.pop_front());
    if (acc) begin
      if (req_wr) mm[int'(req_addr)] = req_wdata;
      else begin
        r.cyc = cyc;
        if (mm.exists(int'(req_addr))) begin r.data = mm[int'(req_addr)]; r.known = 1; end
`ifdef CT_F_SPSRAM_INIT_EN
        else begin r.data = '0; r.known = 1; end
`else
        else begin r.data = '0; r.known = 0; end
`endif
        q.push_back(r);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk); #1; cyc++;
  endtask

  task automatic cycle();
    eval(); tick();
  endtask

  task automatic drive(input bit v, input bit w, input int a, input logic [DW-1:0] d, input bit rr);
    req_vld = v; req_wr = w; req_addr = AW'(a); req_wdata = d; rsp_rdy = rr;
  endtask

  // Called in the first cycle after cpurst_b rises.
  task automatic post_release();
`ifdef CT_F_SPSRAM_INIT_EN
    int errs;
    errs = 0;
    drive(1, 0, 5, '0, 1);
    for (int i = 0; i < (1<<AW); i++) begin
      @(negedge clk);
      if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_a !== AW'(i) || sram_wen !== '0 ||
          sram_d !== '0 || req_rdy !== 1'b0 || init_done !== 1'b0) errs++;
      @(posedge clk); #1; cyc++;
    end
    chk("init_sweep_errs", 32'(errs), '0);
    mm.delete();
    m_run = 1; chk_model = 1;
    drive(1, 0, 'h1FFF, '0, 1);
    eval();
    chk("init_done_after_sweep", init_done, 1'b1);
    tick();
    drive(0, 0, 0, '0, 1);
    cycle();
    eval();
    chk("rd_1fff_vld", rsp_vld, 1'b1);
    chk("rd_1fff_data", rsp_rdata, '0);
    tick();
`else
    m_run = 1; chk_model = 1;
    drive(1, 1, 7, {16{8'h55}}, 1);
    eval();
    chk("t6_first_rdy", req_rdy, 1'b1);
    chk("t6_first_cen", sram_cen, 1'b0);
    tick();
    drive(1, 0, 7, '0, 1);
    cycle();
    drive(0, 0, 0, '0, 1);
    cycle();
    eval();
    chk("t6_rd_vld", rsp_vld, 1'b1);
    chk("t6_rd_data", rsp_rdata, {16{8'h55}});
    tick();
`endif
  endtask

  initial begin
    logic [DW-1:0] dd;
    logic [7:0]    vbits;
    int            acc_cyc, lat;
    bit            found;
    logic [DW-1:0] got[$];

    tv[0]  = '{1,0,0,0, 1,0,1,0, 0,'0};
    tv[1]  = '{1,0,1,0, 1,0,1,0, 0,'0};
    tv[2]  = '{1,0,2,0, 0,1,1,1, 1,pat(0)};
    tv[3]  = '{1,0,2,0, 0,1,1,1, 1,pat(0)};
    tv[4]  = '{1,0,2,1, 1,0,1,1, 1,pat(0)};
    tv[5]  = '{0,0,0,1, 1,1,1,1, 1,pat(1)};
    tv[6]  = '{0,0,0,1, 1,1,1,1, 1,pat(2)};
    tv[7]  = '{0,0,0,1, 1,1,1,0, 0,'0};
    tv[8]  = '{1,0,3,0, 1,0,1,0, 0,'0};
    tv[9]  = '{1,0,4,0, 1,0,1,0, 0,'0};
    tv[10] = '{1,1,5,0, 0,1,1,1, 1,pat(3)};
    tv[11] = '{1,1,5,1, 1,0,0,1, 1,pat(3)};
    tv[12] = '{0,0,0,1, 1,1,1,1, 1,pat(4)};
    tv[13] = '{0,0,0,1, 1,1,1,0, 0,'0};

    // Reset values with a request presented
    drive(1, 1, 3, pat(9), 1);
    #12;
    chk("rst_req_rdy", req_rdy, 1'b0);
    chk("rst_rsp_vld", rsp_vld, 1'b0);
    chk("rst_init_done", init_done, 1'b0);
    chk("rst_cen", sram_cen, 1'b1);
    chk("rst_gwen", sram_gwen, 1'b1);
    chk("rst_wen", sram_wen, {DW{1'b1}});
    chk("rst_a", sram_a, '0);
    chk("rst_d", sram_d, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    post_release();

    for (int i = 0; i < 16; i++) begin drive(1, 1, i, pat(i), 1); cycle(); end
    drive(0, 0, 0, '0, 1);
    repeat (3) cycle();

    // Table: fill to depth with rsp_rdy low, write stalled behind blocked reads, drain in order
    foreach (tv[i]) begin
      drive(tv[i].vld, tv[i].wr, int'(tv[i].addr), ~pat(int'(tv[i].addr)), tv[i].rrdy);
      eval();
      chk($sformatf("tv%0d_rdy", i), req_rdy, tv[i].e_rdy);
      chk($sformatf("tv%0d_cen", i), sram_cen, tv[i].e_cen);
      chk($sformatf("tv%0d_gwen", i), sram_gwen, tv[i].e_gwen);
      chk($sformatf("tv%0d_wen", i), sram_wen, {DW{tv[i].e_gwen}});
      chk($sformatf("tv%0d_vld", i), rsp_vld, tv[i].e_vld);
      if (tv[i].e_chkd) chk($sformatf("tv%0d_data", i), rsp_rdata, tv[i].e_data);
      tick();
    end

    // Write then read of the same address on the next cycle
    dd = {32'hDEADBEEF, 64'h0123456789ABCDEF, 32'h00000001};
    drive(1, 1, 'h123, dd, 1);
    cycle();
    drive(1, 0, 'h123, '0, 1);
    eval();
    chk("t2_rd_rdy", req_rdy, 1'b1);
    acc_cyc = cyc;
    tick();
    drive(0, 0, 0, '0, 1);
    found = 0; lat = -1;
    for (int k = 0; k < 10 && !found; k++) begin
      eval();
      if (rsp_vld) begin found = 1; lat = cyc - acc_cyc; chk("t2_data", rsp_rdata, dd); end
      tick();
    end
    chk("t2_latency", 32'(lat), 32'd2);

    // Four back-to-back reads with rsp_rdy high
    vbits = '0;
    for (int k = 0; k < 8; k++) begin
      if (k < 4) drive(1, 0, k, '0, 1); else drive(0, 0, 0, '0, 1);
      eval();
      if (k < 4) chk($sformatf("t3_rdy%0d", k), req_rdy, 1'b1);
      vbits[k] = rsp_vld;
      if (rsp_vld) got.push_back(rsp_rdata);
      tick();
    end
    chk("t3_vld_pattern", vbits, 8'b0011_1100);
    chk("t3_count", 32'(got.size()), 32'd4);
    for (int k = 0; k < 4 && k < got.size(); k++) chk($sformatf("t3_data%0d", k), got[k], pat(k));

    // Random traffic against the model
    for (int k = 0; k < 1500; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 15),
            {$urandom, $urandom, $urandom, $urandom}, $urandom_range(0, 3) != 0);
      cycle();
    end
    drive(0, 0, 0, '0, 1);
    repeat (4) cycle();

    // Reset with one read in flight and one entry queued
    drive(1, 0, 1, '0, 0);
    cycle();
    drive(1, 0, 2, '0, 0);
    cycle();
    drive(1, 0, 3, '0, 0);
    rst_n = 1'b0;
    #1;
    chk("t5_rsp_vld", rsp_vld, 1'b0);
    chk("t5_cen", sram_cen, 1'b1);
    chk("t5_req_rdy", req_rdy, 1'b0);
    chk("t5_init_done", init_done, 1'b0);
    chk_model = 0; m_run = 0; q.delete();
    @(posedge clk); #1; cyc++;
    chk("t5_rsp_vld_held", rsp_vld, 1'b0);
    @(posedge clk); #1; cyc++;
    rst_n = 1'b1;
    #1;
    chk("t5_flushed", rsp_vld, 1'b0);
    post_release();
    drive(0, 0, 0, '0, 1);
    repeat (3) cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end
endmodule
